nmea_sentence_tx: RTL and testbench
===================================

Name: nmea_sentence_tx

Overview:
- Transmit-side counterpart to the on-board NMEA receive path: builds and serializes NMEA-framed sentences (configuration and commands, e.g. PMTK) toward the GPS module over UART 8N1.
- Upstream logic streams raw payload bytes over a valid/ready handshake.
- The block prepends '$', computes the XOR checksum, appends '*', two uppercase hex digits and CR LF, and drives the serial line.
- Sits beside the GPS receive wrapper, driving the GPS module's RX pin.

Parameters:
- SYSCLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate; BIT_CYCLES = SYSCLK_FREQ/BAUD (integer division).
- MAX_PAYLOAD, 80, maximum payload bytes per sentence before forced termination.

Ports:
- sclk  input  1  system clock.
- rstn  input  1  reset, asynchronous, active-low.
- pl_data  input  8  payload byte.
- pl_valid  input  1  pl_data valid; held high in IDLE requests a new sentence.
- pl_last  input  1  marks the final payload byte; qualified by pl_valid&&pl_ready.
- pl_ready  output  1  block accepts pl_data this cycle.
- txd  output  1  UART serial out, idle high.
- busy  output  1  sentence in progress.
- sent  output  1  one-cycle pulse, sentence fully transmitted.
- trunc  output  1  one-cycle pulse, payload forcibly terminated at MAX_PAYLOAD.

Behaviour:
- Clock and reset: one clock, sclk. Reset is asynchronous, active-low on rstn.
- Reset values: txd=1, pl_ready=0, busy=0, sent=0, trunc=0, FSM=IDLE, checksum=0, count=0.
- Reset mid-frame: txd goes high immediately, and the partial sentence is discarded.
- Byte engine:
  - 10-bit frame: start 0, data LSB first, stop 1.
  - Each bit lasts exactly BIT_CYCLES cycles.
  - Consecutive bytes within a sentence go back-to-back, with no idle between a stop bit and the next start bit, when the next byte is available.
- FSM states: IDLE -> DOLLAR -> PAYLOAD -> STAR -> CS_HI -> CS_LO -> CR -> LF -> DONE -> IDLE.
- IDLE:
  - pl_valid sampled high at cycle N -> busy=1 and start bit of '$' (0x24) begins at N+1.
  - The payload byte is not consumed, and checksum is cleared to 0.
- PAYLOAD:
  - pl_ready=1 for exactly the cycle in which the engine can load a new byte: engine idle, or the final cycle of the current stop bit.
  - Transfer occurs on pl_valid&&pl_ready.
  - On transfer: checksum ^= pl_data, count++, and the byte is transmitted verbatim (no escaping; '$' and '*' in the payload are upstream's responsibility).
  - pl_valid low while ready: txd stays high (gap permitted). The checksum and sentence are unaffected, and pl_ready stays asserted until a transfer occurs.
  - Transfer with pl_last=1 -> STAR.
  - Transfer where count reaches MAX_PAYLOAD without pl_last -> trunc pulses the next cycle, then STAR.
  - Bytes offered after truncation are not accepted in this sentence. They start a new sentence after DONE.
- STAR: sends '*' (0x2A).
- CS_HI/CS_LO: send the upper then lower nibble of checksum as uppercase ASCII hex ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
- CR/LF: send 0x0D then 0x0A.
- DONE:
  - The cycle after the LF stop bit ends, sent=1 for one cycle and busy=0.
  - Returns to IDLE; a new sentence may start the following cycle.
- pl_ready is 0 in every state except PAYLOAD.
- pl_last is ignored unless the transfer occurs.
- The empty payload case cannot occur: sentence start requires pl_valid, and the first PAYLOAD transfer takes that byte.

Test Plan:
- SYSCLK_FREQ=1_000_000, BAUD=100_000 (10 cycles/bit); payload "PMTK220,1000" with last on the final '0' -> txd carries "$PMTK220,1000*1F\r\n", 18 frames / 1800 cycles with no inter-byte gaps; sent pulses once; busy spans exactly that window.
- Single-byte payload 'A' (0x41, last) -> "$A*41\r\n"; checksum digits 0x34, 0x31.
- Payload "GPQ" with pl_valid dropped for 50 cycles after 'P' -> txd high during the gap; output "$GPQ*xx\r\n" with checksum 0x47^0x50^0x51=0x46 -> "*46".
- MAX_PAYLOAD=4; 6 bytes "ABCDEF" with no last -> "$ABCD*04\r\n" (0x41^0x42^0x43^0x44=0x04); trunc pulses once; 'E' is not accepted before sent.
- Assert rstn low mid-data-bit of the third payload byte -> txd=1, busy=0, pl_ready=0 immediately. After release, a fresh sentence "$A*41\r\n" transmits correctly with checksum starting from 0.

Source files
------------

// File: rtl/nmea_sentence_tx_if.sv
// Payload stream handshake between upstream sentence source and nmea_sentence_tx.
//   pl_data  : payload byte
//   pl_valid : pl_data valid (also requests a new sentence when the block is idle)
//   pl_last  : final payload byte of the sentence, qualified by the transfer
//   pl_ready : block accepts pl_data this cycle
interface nmea_sentence_tx_if;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       pl_ready;

    modport master (
        output pl_data,
        output pl_valid,
        output pl_last,
        input  pl_ready
    );

    modport slave (
        input  pl_data,
        input  pl_valid,
        input  pl_last,
        output pl_ready
    );
endinterface

// File: rtl/nmea_sentence_tx.sv
// NMEA sentence transmitter: frames an upstream payload stream as
// "$<payload>*HH\r\n" (HH = XOR checksum in uppercase hex) and serializes
// it on a UART 8N1 line toward the GPS module.
// Ports:
//   sclk  : system clock
//   rstn  : asynchronous active-low reset
//   pl    : payload stream (slave side of nmea_sentence_tx_if)
//   txd   : serial out, idle high
//   busy  : sentence in progress
//   sent  : one-cycle pulse after the final LF stop bit
//   trunc : one-cycle pulse when the payload is cut at MAX_PAYLOAD bytes
module nmea_sentence_tx #(
    parameter int unsigned SYSCLK_FREQ = 100_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned MAX_PAYLOAD = 80
) (
    input  logic               sclk,
    input  logic               rstn,
    nmea_sentence_tx_if.slave  pl,
    output logic               txd,
    output logic               busy,
    output logic               sent,
    output logic               trunc
);

    localparam int unsigned BIT_CYCLES = SYSCLK_FREQ / BAUD;
    localparam int unsigned CYC_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned CNT_W      = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned BIT_W      = 4;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] STOP_BIT  = BIT_W'(9);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PAYLOAD);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DOLLAR,
        S_PAYLOAD,
        S_STAR,
        S_CS_HI,
        S_CS_LO,
        S_CR,
        S_LF,
        S_DONE
    } state_t;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    state_t             state_q, state_d;
    logic               active_q, active_d;   // byte engine has a frame in flight
    logic [CYC_W-1:0]   cyc_q, cyc_d;         // cycle within current bit
    logic [BIT_W-1:0]   bit_q, bit_d;         // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]         sh_q, sh_d;           // remaining data bits then stop bit
    logic [7:0]         cs_q, cs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               txd_d, busy_d, sent_d, trunc_d, ready_d;

    logic               eng_last_c;
    logic               can_load_c;
    logic               load_c;
    logic [7:0]         load_byte_c;

    // State register and registered outputs.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            active_q    <= 1'b0;
            cyc_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '1;
            cs_q        <= '0;
            cnt_q       <= '0;
            txd         <= 1'b1;
            busy        <= 1'b0;
            sent        <= 1'b0;
            trunc       <= 1'b0;
            pl.pl_ready <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            cs_q        <= cs_d;
            cnt_q       <= cnt_d;
            txd         <= txd_d;
            busy        <= busy_d;
            sent        <= sent_d;
            trunc       <= trunc_d;
            pl.pl_ready <= ready_d;
        end
    end

    // Final cycle of a stop bit: the next frame may start on the following cycle.
    assign eng_last_c = active_q && (cyc_q == CYC_LAST) && (bit_q == STOP_BIT);
    assign can_load_c = !active_q || eng_last_c;

    // Next-state, byte engine and output logic.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        cs_d        = cs_q;
        cnt_d       = cnt_q;
        txd_d       = txd;
        busy_d      = busy;
        sent_d      = 1'b0;
        trunc_d     = 1'b0;
        ready_d     = 1'b0;
        load_c      = 1'b0;
        load_byte_c = 8'h00;

        // Advance the bit timer of the frame in flight.
        if (active_q) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                if (bit_q == STOP_BIT) begin
                    active_d = 1'b0;
                    txd_d    = 1'b1;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                    txd_d = sh_q[0];
                    sh_d  = {1'b1, sh_q[8:1]};
                end
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                // The requesting byte is left on the bus; '$' goes out first.
                if (pl.pl_valid) begin
                    load_c      = 1'b1;
                    load_byte_c = CH_DOLLAR;
                    cs_d        = '0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = S_DOLLAR;
                end
            end
            S_DOLLAR: begin
                state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (pl.pl_ready && pl.pl_valid) begin
                    load_c      = 1'b1;
                    load_byte_c = pl.pl_data;
                    cs_d        = cs_q ^ pl.pl_data;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (pl.pl_last) begin
                        state_d = S_STAR;
                    end else if (cnt_d == CNT_LIMIT) begin
                        trunc_d = 1'b1;
                        state_d = S_STAR;
                    end
                end
            end
            S_STAR: begin
                if (can_load_c) begin
                    load_c      = 1'b1;
                    load_byte_c = CH_STAR;
                    state_d     = S_CS_HI;
                end
            end
            S_CS_HI: begin
                if (can_load_c) begin
                    load_c      = 1'b1;
                    load_byte_c = hex_ascii(cs_q[7:4]);
                    state_d     = S_CS_LO;
                end
            end
            S_CS_LO: begin
                if (can_load_c) begin
                    load_c      = 1'b1;
                    load_byte_c = hex_ascii(cs_q[3:0]);
                    state_d     = S_CR;
                end
            end
            S_CR: begin
                if (can_load_c) begin
                    load_c      = 1'b1;
                    load_byte_c = CH_CR;
                    state_d     = S_LF;
                end
            end
            S_LF: begin
                if (can_load_c) begin
                    load_c      = 1'b1;
                    load_byte_c = CH_LF;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // Sentence completes once the LF stop bit has fully elapsed.
                if (eng_last_c) begin
                    sent_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start a new frame back-to-back with the stop bit just ending.
        if (load_c) begin
            active_d = 1'b1;
            cyc_d    = '0;
            bit_d    = '0;
            txd_d    = 1'b0;
            sh_d     = {1'b1, load_byte_c};
        end

        // Ready is registered, so it is derived from next-cycle engine state.
        ready_d = (state_d == S_PAYLOAD) &&
                  (!active_d || ((cyc_d == CYC_LAST) && (bit_d == STOP_BIT)));
    end

endmodule

// File: tb/tb_nmea_sentence_tx.sv
// Self-checking bench for nmea_sentence_tx: two instances (MAX_PAYLOAD 80 and 4),
// a UART 8N1 decoder per instance, and a sentence-level reference model.
`timescale 1ns/1ps
module tb_nmea_sentence_tx;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int BITC  = 10;
    localparam int FRAME = 10 * BITC;
    localparam int MAX_A = 80;
    localparam int MAX_B = 4;

    typedef logic [7:0] bq_t[$];

    logic sclk = 1'b0;
    logic rstn = 1'b0;
    always #5 sclk = ~sclk;

    nmea_sentence_tx_if a_if ();
    nmea_sentence_tx_if b_if ();

    logic txd_a, busy_a, sent_a, trunc_a;
    logic txd_b, busy_b, sent_b, trunc_b;

    nmea_sentence_tx #(.SYSCLK_FREQ(CLK_HZ), .BAUD(BAUD), .MAX_PAYLOAD(MAX_A)) dut_a (
        .sclk(sclk), .rstn(rstn), .pl(a_if),
        .txd(txd_a), .busy(busy_a), .sent(sent_a), .trunc(trunc_a)
    );

    nmea_sentence_tx #(.SYSCLK_FREQ(CLK_HZ), .BAUD(BAUD), .MAX_PAYLOAD(MAX_B)) dut_b (
        .sclk(sclk), .rstn(rstn), .pl(b_if),
        .txd(txd_b), .busy(busy_b), .sent(sent_b), .trunc(trunc_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int epoch    = 0;

    bq_t rx_a, rx_b;
    int  st_a[$], st_b[$];
    int  ferr_a = 0, ferr_b = 0;
    int  busy_cnt_a = 0, busy_cnt_b = 0;
    int  sent_cnt_a = 0, sent_cnt_b = 0;
    int  trunc_cnt_a = 0, trunc_cnt_b = 0;

    always @(posedge sclk) cyc_cnt <= cyc_cnt + 1;

    // Per-cycle output statistics, sampled just after the active edge.
    always begin
        @(posedge sclk);
        #1;
        if (busy_a)  busy_cnt_a++;
        if (busy_b)  busy_cnt_b++;
        if (sent_a)  sent_cnt_a++;
        if (sent_b)  sent_cnt_b++;
        if (trunc_a) trunc_cnt_a++;
        if (trunc_b) trunc_cnt_b++;
    end

    function automatic logic txd_of(input int sel);
        return (sel != 0) ? txd_b : txd_a;
    endfunction

    function automatic logic ready_of(input int sel);
        return (sel != 0) ? b_if.pl_ready : a_if.pl_ready;
    endfunction

    function automatic logic sent_of(input int sel);
        return (sel != 0) ? sent_b : sent_a;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [7:0] d, input logic l);
        if (sel != 0) begin
            b_if.pl_valid = v; b_if.pl_data = d; b_if.pl_last = l;
        end else begin
            a_if.pl_valid = v; a_if.pl_data = d; a_if.pl_last = l;
        end
    endtask

    // UART 8N1 receiver: samples each bit at its centre; frames cut by reset are dropped.
    task automatic mon(input int sel);
        logic [7:0] b;
        int st;
        int ep;
        logic bad;
        forever begin
            @(posedge sclk);
            #1;
            if (rstn && txd_of(sel) == 1'b0) begin
                st  = cyc_cnt;
                ep  = epoch;
                bad = 1'b0;
                repeat (BITC / 2) @(posedge sclk);
                #1;
                if (txd_of(sel) !== 1'b0) bad = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(posedge sclk);
                    #1;
                    b[i] = txd_of(sel);
                end
                repeat (BITC) @(posedge sclk);
                #1;
                if (txd_of(sel) !== 1'b1) bad = 1'b1;
                if (ep == epoch) begin
                    if (sel != 0) begin
                        rx_b.push_back(b); st_b.push_back(st); if (bad) ferr_b++;
                    end else begin
                        rx_a.push_back(b); st_a.push_back(st); if (bad) ferr_a++;
                    end
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
        return q;
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n) - 8'd10;
    endfunction

    // Reference: the line a sentence should produce on the wire.
    function automatic bq_t model_line(input bq_t pl, input int maxp);
        bq_t line;
        int n;
        logic [7:0] x;
        x = 8'h00;
        n = (pl.size() < maxp) ? pl.size() : maxp;
        line.push_back("$");
        for (int k = 0; k < n; k++) begin
            line.push_back(pl[k]);
            x = x ^ pl[k];
        end
        line.push_back("*");
        line.push_back(hexc(x[7:4]));
        line.push_back(hexc(x[3:0]));
        line.push_back(8'h0D);
        line.push_back(8'h0A);
        return line;
    endfunction

    task automatic clear_stats();
        rx_a.delete(); rx_b.delete(); st_a.delete(); st_b.delete();
        ferr_a = 0; ferr_b = 0;
        busy_cnt_a = 0; busy_cnt_b = 0;
        sent_cnt_a = 0; sent_cnt_b = 0;
        trunc_cnt_a = 0; trunc_cnt_b = 0;
    endtask

    // Drive one sentence's payload; returns at the sent pulse, at abort_at, or on budget expiry.
    task automatic run(input int sel, input bq_t pl, input bit use_last, input int gap_idx,
                       input int gap_len, input bit keep, input int abort_at,
                       output int acc, output bit done, output bit gap_bad, output int t0);
        int i;
        int t;
        bit armed;
        int gcnt;
        i = 0; t = 0; armed = 1'b0; gcnt = 0;
        acc = 0; done = 1'b0; gap_bad = 1'b0; t0 = -1;
        while (!done && t < 6000) begin
            @(negedge sclk);
            t++;
            if (t == abort_at) begin
                rstn = 1'b0;
                set_in(sel, 1'b0, 8'h00, 1'b0);
                return;
            end
            if (sent_of(sel)) begin
                done = 1'b1;
                if (!keep) set_in(sel, 1'b0, 8'h00, 1'b0);
            end else if (armed) begin
                set_in(sel, 1'b0, 8'h00, 1'b0);
                if (ready_of(sel)) begin
                    if (txd_of(sel) !== 1'b1) gap_bad = 1'b1;
                    gcnt++;
                    if (gcnt == gap_len) armed = 1'b0;
                end else if (gcnt > 0) begin
                    gap_bad = 1'b1;
                end
            end else if (i < pl.size()) begin
                if (t0 < 0) t0 = cyc_cnt;
                set_in(sel, 1'b1, pl[i], use_last && (i == pl.size() - 1));
                if (ready_of(sel)) begin
                    if (i == gap_idx && gap_len > 0) armed = 1'b1;
                    i++;
                    acc++;
                end
            end else begin
                set_in(sel, 1'b0, 8'h00, 1'b0);
            end
        end
    endtask

    task automatic verify(input string tag, input int sel, input bq_t exp, input int exp_acc,
                          input int acc, input int gap_len, input bit exp_trunc, input bit done,
                          input bit gap_bad, input int exp_lat, input int t0);
        bq_t got;
        int st[$];
        int bc, sc, tc, fe;
        if (sel != 0) begin
            got = rx_b; st = st_b; bc = busy_cnt_b; sc = sent_cnt_b; tc = trunc_cnt_b; fe = ferr_b;
        end else begin
            got = rx_a; st = st_a; bc = busy_cnt_a; sc = sent_cnt_a; tc = trunc_cnt_a; fe = ferr_a;
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".accepted"}, 32'(acc), 32'(exp_acc));
        check({tag, ".frames"}, 32'(got.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++)
            check($sformatf("%s.byte%0d", tag, k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF,
                  32'(exp[k]));
        check({tag, ".frame_err"}, 32'(fe), 32'd0);
        if (st.size() > 0) begin
            check({tag, ".start_lat"}, 32'(st[0] - t0), 32'(exp_lat));
            check({tag, ".span"}, 32'(st[st.size() - 1] - st[0]),
                  32'(FRAME * (exp.size() - 1) + gap_len));
        end
        check({tag, ".busy_cycles"}, 32'(bc), 32'(FRAME * exp.size() + gap_len));
        check({tag, ".sent_pulses"}, 32'(sc), 32'd1);
        check({tag, ".trunc_pulses"}, 32'(tc), 32'(exp_trunc));
        if (gap_len > 0) check({tag, ".gap_idle"}, 32'(gap_bad), 32'd0);
    endtask

    // Global time bound.
    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t pl, exp;
        int acc, t0, n, gi, gl, mx, sel;
        bit done, gbad, ul, et;

        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        rstn = 1'b0;
        repeat (3) @(negedge sclk);
        check("rst.txd_a",   32'(txd_a),   32'd1);
        check("rst.ready_a", 32'(a_if.pl_ready), 32'd0);
        check("rst.busy_a",  32'(busy_a),  32'd0);
        check("rst.sent_a",  32'(sent_a),  32'd0);
        check("rst.trunc_a", 32'(trunc_a), 32'd0);
        check("rst.txd_b",   32'(txd_b),   32'd1);
        check("rst.ready_b", 32'(b_if.pl_ready), 32'd0);
        check("rst.busy_b",  32'(busy_b),  32'd0);
        rstn = 1'b1;
        repeat (3) @(negedge sclk);
        clear_stats();

        // PMTK command sentence.
        pl = str2q("PMTK220,1000");
        run(0, pl, 1'b1, -1, 0, 1'b0, 0, acc, done, gbad, t0);
        check("pmtk.cs_hi", (rx_a.size() > 14) ? 32'(rx_a[14]) : 32'hFFFF_FFFF, 32'h31);
        check("pmtk.cs_lo", (rx_a.size() > 15) ? 32'(rx_a[15]) : 32'hFFFF_FFFF, 32'h46);
        verify("pmtk", 0, model_line(pl, MAX_A), pl.size(), acc, 0, 1'b0, done, gbad, 1, t0);
        clear_stats();

        // Single-byte payload.
        pl = str2q("A");
        run(0, pl, 1'b1, -1, 0, 1'b0, 0, acc, done, gbad, t0);
        check("one.cs_hi", (rx_a.size() > 3) ? 32'(rx_a[3]) : 32'hFFFF_FFFF, 32'h34);
        check("one.cs_lo", (rx_a.size() > 4) ? 32'(rx_a[4]) : 32'hFFFF_FFFF, 32'h31);
        verify("one", 0, model_line(pl, MAX_A), 1, acc, 0, 1'b0, done, gbad, 1, t0);
        clear_stats();

        // Upstream gap of 50 cycles after 'P'.
        pl = str2q("GPQ");
        run(0, pl, 1'b1, 1, 50, 1'b0, 0, acc, done, gbad, t0);
        check("gap.cs_hi", (rx_a.size() > 5) ? 32'(rx_a[5]) : 32'hFFFF_FFFF, 32'h34);
        check("gap.cs_lo", (rx_a.size() > 6) ? 32'(rx_a[6]) : 32'hFFFF_FFFF, 32'h36);
        verify("gap", 0, model_line(pl, MAX_A), 3, acc, 50, 1'b0, done, gbad, 1, t0);
        clear_stats();

        // Truncation at 4 bytes; leftover bytes stay on the bus and form the next sentence.
        pl = str2q("ABCDEF");
        run(1, pl, 1'b0, -1, 0, 1'b1, 0, acc, done, gbad, t0);
        check("trunc.cs_lo", (rx_b.size() > 7) ? 32'(rx_b[7]) : 32'hFFFF_FFFF, 32'h34);
        verify("trunc", 1, model_line(pl, MAX_B), 4, acc, 0, 1'b1, done, gbad, 1, t0);
        clear_stats();
        pl = str2q("EF");
        run(1, pl, 1'b1, -1, 0, 1'b0, 0, acc, done, gbad, t0);
        verify("after_trunc", 1, model_line(pl, MAX_B), 2, acc, 0, 1'b0, done, gbad, 0, t0);
        clear_stats();

        // Reset in the middle of a data bit of the third payload byte.
        pl = str2q("ABCDEF");
        run(0, pl, 1'b1, -1, 0, 1'b0, 337, acc, done, gbad, t0);
        #1;
        check("midrst.accepted", 32'(acc), 32'd3);
        check("midrst.txd",   32'(txd_a), 32'd1);
        check("midrst.busy",  32'(busy_a), 32'd0);
        check("midrst.ready", 32'(a_if.pl_ready), 32'd0);
        epoch++;
        repeat (100) @(negedge sclk);
        rstn = 1'b1;
        repeat (2) @(negedge sclk);
        clear_stats();
        pl = str2q("A");
        run(0, pl, 1'b1, -1, 0, 1'b0, 0, acc, done, gbad, t0);
        verify("post_rst", 0, model_line(pl, MAX_A), 1, acc, 0, 1'b0, done, gbad, 1, t0);
        clear_stats();

        // Randomized sentences on both instances.
        for (int r = 0; r < 10; r++) begin
            sel = (r < 6) ? 0 : 1;
            mx  = (sel != 0) ? MAX_B : MAX_A;
            n   = (sel != 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(1, 12));
            pl.delete();
            for (int k = 0; k < n; k++) pl.push_back(8'($urandom_range(0, 255)));
            ul = (n < mx) ? 1'b1 : 1'($urandom_range(0, 1));
            et = !(ul && n <= mx);
            gi = -1; gl = 0;
            if (sel == 0 && n >= 2 && $urandom_range(0, 1) == 1) begin
                gi = int'($urandom_range(0, n - 2));
                gl = int'($urandom_range(1, 30));
            end
            exp = model_line(pl, mx);
            run(sel, pl, ul, gi, gl, 1'b0, 0, acc, done, gbad, t0);
            verify($sformatf("rnd%0d", r), sel, exp, (n < mx) ? n : mx, acc, gl, et, done, gbad,
                   1, t0);
            clear_stats();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
